// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants one of NUM_SRC producers per cycle and registers its packet onto the bus.
// Define CDB_AGE_BOOST_EN to add per-port age counters that force a grant after MAX_WAIT waiting cycles.
module cdb_arbiter #(
  parameter int NUM_SRC  = 5,
  parameter int DATA_W   = 133,
  parameter int RR_EN    = 1,
  parameter int SRC_W    = 3,
  parameter int MAX_WAIT = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        req,
  input  logic [NUM_SRC*DATA_W-1:0] din,
  input  logic                      flush,
  output logic [NUM_SRC-1:0]        gnt,
  output logic [DATA_W-1:0]         dout,
  output logic                      dout_valid,
  output logic [SRC_W-1:0]          dout_src
);

  localparam int IDX_W = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1;

  if ((2 ** SRC_W) < NUM_SRC || NUM_SRC < 2 || MAX_WAIT < 1) begin : g_param_check
    $error("cdb_arbiter: SRC_W too narrow for NUM_SRC, or NUM_SRC/MAX_WAIT out of range");
  end

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] win_idx;
  logic             win_any;
  logic             grant_fire;

`ifdef CDB_AGE_BOOST_EN
  localparam int AGE_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_WAIT);

  logic [AGE_W-1:0]   age [NUM_SRC];
  logic [NUM_SRC-1:0] boosted;

  always_comb begin
    boosted = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      boosted[i] = req[i] && (age[i] == AGE_MAX);
    end
  end
`endif

  // Rotating search from ptr in RR mode; plain ascending search in fixed mode.
  always_comb begin
    int idx;
    idx     = 0;
    win_any = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (RR_EN != 0) ? ((int'(ptr) + k) % NUM_SRC) : k;
      if (!win_any && req[idx]) begin
        win_any = 1'b1;
        win_idx = IDX_W'(idx);
      end
    end
`ifdef CDB_AGE_BOOST_EN
    if (|boosted) begin
      win_any = 1'b1;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
        if (boosted[k]) win_idx = IDX_W'(k);
      end
    end
`endif
  end

  assign grant_fire = win_any && !flush && rst_n;
  assign gnt        = grant_fire ? (NUM_SRC'(1) << win_idx) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_src   <= '0;
      ptr        <= '0;
    end else begin
      if (grant_fire) begin
        dout       <= din[int'(win_idx) * DATA_W +: DATA_W];
        dout_valid <= 1'b1;
        dout_src   <= SRC_W'(win_idx);
      end else begin
        dout       <= '0;
        dout_valid <= 1'b0;
        dout_src   <= '0;
      end
      if (RR_EN != 0 && grant_fire) begin
        ptr <= (win_idx == IDX_W'(NUM_SRC - 1)) ? '0 : win_idx + IDX_W'(1);
      end
    end
  end

`ifdef CDB_AGE_BOOST_EN
  // Counters hold their value across a flush so waiting ports keep their accumulated age.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) age[i] <= '0;
    end else if (!flush) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!req[i] || gnt[i]) begin
          age[i] <= '0;
        end else if (age[i] != AGE_MAX) begin
          age[i] <= age[i] + AGE_W'(1);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: one round-robin and one fixed-priority instance share stimulus.
// Age-boost sequences run only when CDB_AGE_BOOST_EN is defined.
module tb_cdb_arbiter;

  localparam int N     = 5;
  localparam int DW    = 133;
  localparam int SW    = 3;
  localparam int MW_RR = 15;
  localparam int MW_FX = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*DW-1:0] din;
  logic            flush;

  logic [N-1:0]  gnt_rr, gnt_fx;
  logic [DW-1:0] dout_rr, dout_fx;
  logic          valid_rr, valid_fx;
  logic [SW-1:0] src_rr, src_fx;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_SRC(N), .DATA_W(DW), .RR_EN(1), .SRC_W(SW), .MAX_WAIT(MW_RR)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din), .flush(flush),
    .gnt(gnt_rr), .dout(dout_rr), .dout_valid(valid_rr), .dout_src(src_rr)
  );

  cdb_arbiter #(.NUM_SRC(N), .DATA_W(DW), .RR_EN(0), .SRC_W(SW), .MAX_WAIT(MW_FX)) dut_fx (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din), .flush(flush),
    .gnt(gnt_fx), .dout(dout_fx), .dout_valid(valid_fx), .dout_src(src_fx)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: index 0 = round-robin instance, 1 = fixed-priority instance.
  int            m_ptr;
  logic [DW-1:0] m_dout  [2];
  logic          m_valid [2];
  int            m_src   [2];
  int            m_age   [2][N];
  int            m_win   [2];

  typedef struct packed {
    logic [N-1:0]  req;
    logic          flush;
    logic [N-1:0]  rr_gnt;
    logic          rr_valid;
    logic [SW-1:0] rr_src;
    logic [N-1:0]  fx_gnt;
    logic          fx_valid;
    logic [SW-1:0] fx_src;
  } vec_t;

  vec_t vecs [9];

  task automatic checkOutput(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic [N*DW-1:0] d, input logic f);
    req   = r;
    din   = d;
    flush = f;
  endtask

  function automatic logic [N*DW-1:0] rand_din();
    logic [N*DW-1:0] v;
    v = '0;
    for (int i = 0; i < (N * DW + 31) / 32; i++) v = (v << 32) | (N*DW)'($urandom());
    return v;
  endfunction

`ifdef CDB_AGE_BOOST_EN
  function automatic int max_wait(input int inst);
    return (inst == 0) ? MW_RR : MW_FX;
  endfunction
`endif

  function automatic int model_winner(input int inst);
    if (!rst_n || flush) return -1;
`ifdef CDB_AGE_BOOST_EN
    for (int p = 0; p < N; p++) if (req[p] && m_age[inst][p] >= max_wait(inst)) return p;
`endif
    if (inst == 0) begin
      for (int p = m_ptr; p < N; p++) if (req[p]) return p;
      for (int p = 0; p < m_ptr; p++) if (req[p]) return p;
    end else begin
      for (int p = 0; p < N; p++) if (req[p]) return p;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_gnt(input int w);
    logic [N-1:0] g;
    g = '0;
    if (w >= 0) g[w] = 1'b1;
    return g;
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    for (int i = 0; i < 2; i++) begin
      m_dout[i]  = '0;
      m_valid[i] = 1'b0;
      m_src[i]   = 0;
      for (int p = 0; p < N; p++) m_age[i][p] = 0;
    end
  endtask

  task automatic model_check();
    for (int i = 0; i < 2; i++) m_win[i] = model_winner(i);
    checkOutput("rr_gnt",   DW'(gnt_rr),   DW'(exp_gnt(m_win[0])));
    checkOutput("rr_dout",  dout_rr,       m_dout[0]);
    checkOutput("rr_valid", DW'(valid_rr), DW'(m_valid[0]));
    checkOutput("rr_src",   DW'(src_rr),   DW'(m_src[0]));
    checkOutput("fx_gnt",   DW'(gnt_fx),   DW'(exp_gnt(m_win[1])));
    checkOutput("fx_dout",  dout_fx,       m_dout[1]);
    checkOutput("fx_valid", DW'(valid_fx), DW'(m_valid[1]));
    checkOutput("fx_src",   DW'(src_fx),   DW'(m_src[1]));
  endtask

  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
`ifdef CDB_AGE_BOOST_EN
      if (!flush) begin
        for (int p = 0; p < N; p++) begin
          if (!req[p] || p == m_win[i]) m_age[i][p] = 0;
          else if (m_age[i][p] < max_wait(i)) m_age[i][p]++;
        end
      end
`endif
      if (m_win[i] >= 0) begin
        m_dout[i]  = din[m_win[i] * DW +: DW];
        m_valid[i] = 1'b1;
        m_src[i]   = m_win[i];
      end else begin
        m_dout[i]  = '0;
        m_valid[i] = 1'b0;
        m_src[i]   = 0;
      end
    end
    if (m_win[0] >= 0) m_ptr = (m_win[0] + 1) % N;
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic run_cycle(input logic [N-1:0] r, input logic [N*DW-1:0] d, input logic f);
    applyStimulus(r, d, f);
    @(negedge clk);
    model_check();
    finish_cycle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [N*DW-1:0] d;
    logic [N-1:0]    fx_boost_seq [5];

    vecs[0] = '{5'b00110, 1'b0, 5'b00010, 1'b0, 3'd0, 5'b00010, 1'b0, 3'd0};
    vecs[1] = '{5'b00110, 1'b0, 5'b00100, 1'b1, 3'd1, 5'b00010, 1'b1, 3'd1};
    vecs[2] = '{5'b00110, 1'b0, 5'b00010, 1'b1, 3'd2, 5'b00010, 1'b1, 3'd1};
    vecs[3] = '{5'b00000, 1'b0, 5'b00000, 1'b1, 3'd1, 5'b00000, 1'b1, 3'd1};
    vecs[4] = '{5'b11111, 1'b0, 5'b00100, 1'b0, 3'd0, 5'b00001, 1'b0, 3'd0};
    vecs[5] = '{5'b11111, 1'b0, 5'b01000, 1'b1, 3'd2, 5'b00001, 1'b1, 3'd0};
    vecs[6] = '{5'b01001, 1'b1, 5'b00000, 1'b1, 3'd3, 5'b00000, 1'b1, 3'd0};
    vecs[7] = '{5'b01001, 1'b0, 5'b00001, 1'b0, 3'd0, 5'b00001, 1'b0, 3'd0};
    vecs[8] = '{5'b00000, 1'b0, 5'b00000, 1'b1, 3'd0, 5'b00000, 1'b1, 3'd0};

    rst_n = 1'b0;
    applyStimulus('1, rand_din(), 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    checkOutput("reset_gnt_rr",   DW'(gnt_rr),   '0);
    checkOutput("reset_gnt_fx",   DW'(gnt_fx),   '0);
    checkOutput("reset_dout_rr",  dout_rr,       '0);
    checkOutput("reset_valid_rr", DW'(valid_rr), '0);
    checkOutput("reset_src_fx",   DW'(src_fx),   '0);
    req   = '0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < 9; v++) begin
      applyStimulus(vecs[v].req, rand_din(), vecs[v].flush);
      @(negedge clk);
      model_check();
      checkOutput($sformatf("vec%0d_rr_gnt", v),   DW'(gnt_rr),   DW'(vecs[v].rr_gnt));
      checkOutput($sformatf("vec%0d_rr_valid", v), DW'(valid_rr), DW'(vecs[v].rr_valid));
      checkOutput($sformatf("vec%0d_rr_src", v),   DW'(src_rr),   DW'(vecs[v].rr_src));
      checkOutput($sformatf("vec%0d_fx_gnt", v),   DW'(gnt_fx),   DW'(vecs[v].fx_gnt));
      checkOutput($sformatf("vec%0d_fx_valid", v), DW'(valid_fx), DW'(vecs[v].fx_valid));
      checkOutput($sformatf("vec%0d_fx_src", v),   DW'(src_fx),   DW'(vecs[v].fx_src));
      finish_cycle();
    end

    // Idle bus for 10 cycles; the RR pointer must survive (it sits at 1 after the last grant to port 0).
    repeat (10) run_cycle('0, rand_din(), 1'b0);
    applyStimulus(5'b00011, rand_din(), 1'b0);
    @(negedge clk);
    model_check();
    checkOutput("idle_ptr_rr_gnt", DW'(gnt_rr), DW'(5'b00010));
    finish_cycle();
    run_cycle('0, rand_din(), 1'b0);

`ifdef CDB_AGE_BOOST_EN
    fx_boost_seq[0] = 5'b00001;
    fx_boost_seq[1] = 5'b00001;
    fx_boost_seq[2] = 5'b00001;
    fx_boost_seq[3] = 5'b00010;
    fx_boost_seq[4] = 5'b00001;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(5'b00011, rand_din(), 1'b0);
      @(negedge clk);
      model_check();
      checkOutput($sformatf("boost%0d_fx_gnt", c), DW'(gnt_fx), DW'(fx_boost_seq[c]));
      finish_cycle();
    end
    run_cycle('0, rand_din(), 1'b0);
`else
    fx_boost_seq[0] = '0;
    fx_boost_seq[1] = '0;
    fx_boost_seq[2] = '0;
    fx_boost_seq[3] = '0;
    fx_boost_seq[4] = '0;
`endif

    // Asynchronous reset landing just after a grant edge: the freshly loaded packet is dropped.
    d = rand_din();
    d[4*DW +: DW] = '1;
    applyStimulus(5'b10000, d, 1'b0);
    @(negedge clk);
    model_check();
    checkOutput("mid_rst_gnt_rr", DW'(gnt_rr), DW'(5'b10000));
    finish_cycle();
    checkOutput("mid_rst_loaded_rr", dout_rr, '1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_dout_rr",  dout_rr,       '0);
    checkOutput("mid_rst_valid_rr", DW'(valid_rr), '0);
    checkOutput("mid_rst_gnt_rr0",  DW'(gnt_rr),   '0);
    checkOutput("mid_rst_dout_fx",  dout_fx,       '0);
    checkOutput("mid_rst_valid_fx", DW'(valid_fx), '0);
    model_reset();
    @(negedge clk);
    req   = '0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) run_cycle('0, rand_din(), 1'b0);
    applyStimulus(5'b00011, rand_din(), 1'b0);
    @(negedge clk);
    model_check();
    checkOutput("post_rst_ptr_rr_gnt", DW'(gnt_rr), DW'(5'b00001));
    finish_cycle();

    for (int c = 0; c < 400; c++) begin
      run_cycle(N'($urandom_range(0, 31)), rand_din(), ($urandom_range(0, 7) == 0));
    end
    run_cycle('0, rand_din(), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
